axi_lite_regbank: RTL

Parametrised AXI4-Lite slave register bank. It replaces the fixed four-register peripheral slave with:
- configurable register count and data width;
- byte-strobe writes;
- read-only status registers fed from fabric;
- SLVERR on bad accesses;
- per-register write pulses.

It sits behind the AXI interconnect and is the control/status front end for sensor-monitor cores.

---
 rtl/axi_lite_regbank_if.sv | 48 ++++
 rtl/axi_lite_regbank.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi_lite_regbank.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) with their
// standard S_AXI_ names. The slave modport is used by the register bank,
// the master modport by whatever drives it (interconnect or bench).
interface axi_lite_regbank_if #(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_DATA_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                S_AXI_AWPROT;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                S_AXI_ARPROT;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   s_axi         : AXI4-Lite slave channels (axi_lite_regbank_if.slave)
//   reg_out       : flattened register contents, reg i at [i*W +: W]
//   status_in     : read values for read-only registers (RO slices only)
//   wr_pulse      : one-cycle strobe per register on a successful write
// Writes park AW and W in independent one-entry slots and commit on the
// first edge where both are full. Reads return on the cycle after AR.

// One register: byte-enabled storage. Read-only registers still get a
// cell, but their write enable is tied low so the flops stay at zero.
module axi_lite_regbank_cell #(
  parameter int W = 32
)(
  input  logic           gclk,
  input  logic           grst_n,
  input  logic           we,
  input  logic [W/8-1:0] strb,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   q
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < W/8; b++)
        if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module axi_lite_regbank #(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_NUM_REGS   = 8,
  parameter int                    C_ADDR_WIDTH = 6,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
)(
  input  logic                               ACLK,
  input  logic                               ARESETN,
  axi_lite_regbank_if.slave                  s_axi,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  output logic [C_NUM_REGS-1:0]              wr_pulse
);
  localparam int NB   = C_DATA_WIDTH / 8;
  localparam int LANE = $clog2(NB);
  localparam int IW   = $clog2(C_NUM_REGS);
  localparam logic [C_ADDR_WIDTH:0] NREGS = (C_ADDR_WIDTH+1)'(C_NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] regs_q, status_v;
  logic [C_NUM_REGS-1:0]   we;

  logic                    aw_full, w_full, bvalid, rvalid;
  logic [C_ADDR_WIDTH-1:0] aw_idx, ar_idx;
  logic [C_DATA_WIDTH-1:0] w_data, rdata;
  logic [NB-1:0]           w_strb;
  logic [1:0]              bresp, rresp;
  logic [IW-1:0]           aw_sel, ar_sel;
  logic                    aw_ok, ar_ok, aw_ro, commit, good_wr;
  logic                    aw_hs, w_hs, ar_hs;

  assign status_v = status_in;
  assign reg_out  = regs_q;

  assign s_axi.S_AXI_AWREADY = !aw_full && !bvalid;
  assign s_axi.S_AXI_WREADY  = !w_full && !bvalid;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = !rvalid;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = rresp;

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

  // Index compare uses every address bit above the byte lanes, so
  // out-of-range addresses never alias onto a real register.
  assign aw_ok   = {1'b0, aw_idx} < NREGS;
  assign aw_sel  = aw_idx[IW-1:0];
  assign aw_ro   = C_RO_MASK[aw_sel];
  assign commit  = aw_full && w_full;
  assign good_wr = commit && aw_ok && !aw_ro;

  assign ar_idx = s_axi.S_AXI_ARADDR >> LANE;
  assign ar_ok  = {1'b0, ar_idx} < NREGS;
  assign ar_sel = ar_idx[IW-1:0];

  always_comb begin
    we = '0;
    if (good_wr) we[aw_sel] = 1'b1;
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    axi_lite_regbank_cell #(.W(C_DATA_WIDTH)) u_cell (
      .gclk  (ACLK),
      .grst_n(ARESETN),
      .we    (we[i]),
      .strb  (w_strb),
      .wdata (w_data),
      .q     (regs_q[i])
    );
  end

  // Write side. A slot can only fill while BVALID is low, and commit fires
  // as soon as both are full, so commit never overlaps a pending response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= we;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (aw_ok && !aw_ro) ? OKAY : SLVERR;
      end else if (bvalid && s_axi.S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi.S_AXI_AWADDR >> LANE;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  // Read side. regs_q is sampled before any same-edge commit lands, which
  // gives the pre-write value on a read/write collision.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      if (ar_ok) begin
        rdata <= C_RO_MASK[ar_sel] ? status_v[ar_sel] : regs_q[ar_sel];
        rresp <= OKAY;
      end else begin
        rdata <= '0;
        rresp <= SLVERR;
      end
    end else if (rvalid && s_axi.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  logic unused;
  assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                    s_axi.S_AXI_AWADDR[LANE-1:0], s_axi.S_AXI_ARADDR[LANE-1:0]};
endmodule
